// File: rtl/axil_master_arbiter.sv
// Two-requester arbiter feeding one AXI4-Lite master port.
// Ports: clock/reset; req/we/addr/wdata in, done/rdata/resp out; m_* AXI-Lite master.
module axil_master_arbiter #(
  parameter int ADDR_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [63:0]           wdata,
  output logic [1:0]            done,
  output logic [31:0]           rdata,
  output logic [1:0]            resp,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [31:0]           m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RDATA,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic              last_grant;
  logic              grant;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              gnt_vld;
  logic              gnt_sel;
  logic              gnt_we;
  logic              aw_fin;
  logic              w_fin;
  logic              cmpl;

  logic              awvalid_nx;
  logic              wvalid_nx;
  logic              arvalid_nx;
  logic              bready_nx;
  logic              rready_nx;
  logic [1:0]        done_nx;

  // Arbitration: a lone request wins; a tie goes to the
  // requester that did not win last time.
  always_comb begin
    gnt_vld = |req;
    gnt_sel = 1'b0;
    unique case (req)
      2'b01:   gnt_sel = 1'b0;
      2'b10:   gnt_sel = 1'b1;
      2'b11:   gnt_sel = ~last_grant;
      default: gnt_sel = 1'b0;
    endcase
    gnt_we = gnt_sel ? we[1] : we[0];
  end

  // A channel is finished once its valid has dropped or
  // its handshake happens this cycle.
  assign aw_fin = ~m_awvalid | m_awready;
  assign w_fin  = ~m_wvalid | m_wready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (gnt_vld) begin
          state_nx = gnt_we ? WRITE : READ;
        end
      end
      WRITE: begin
        if (aw_fin && w_fin) begin
          state_nx = WRESP;
        end
      end
      WRESP: begin
        if (m_bvalid) begin
          state_nx = DONE;
        end
      end
      READ: begin
        if (m_arready) begin
          state_nx = RDATA;
        end
      end
      RDATA: begin
        if (m_rvalid) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    awvalid_nx = 1'b0;
    wvalid_nx  = 1'b0;
    arvalid_nx = 1'b0;
    unique case (state)
      IDLE: begin
        awvalid_nx = gnt_vld & gnt_we;
        wvalid_nx  = gnt_vld & gnt_we;
        arvalid_nx = gnt_vld & ~gnt_we;
      end
      WRITE: begin
        awvalid_nx = m_awvalid & ~m_awready;
        wvalid_nx  = m_wvalid & ~m_wready;
      end
      READ: begin
        arvalid_nx = ~m_arready;
      end
      default: begin
        awvalid_nx = 1'b0;
      end
    endcase
    bready_nx = (state_nx == WRESP);
    rready_nx = (state_nx == RDATA);
    cmpl      = (state_nx == DONE);
    done_nx   = cmpl ? {grant, ~grant} : 2'b00;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m_awvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      m_arvalid  <= 1'b0;
      m_bready   <= 1'b0;
      m_rready   <= 1'b0;
      done       <= 2'b00;
      rdata      <= '0;
      resp       <= 2'b00;
    end else begin
      m_awvalid <= awvalid_nx;
      m_wvalid  <= wvalid_nx;
      m_arvalid <= arvalid_nx;
      m_bready  <= bready_nx;
      m_rready  <= rready_nx;
      done      <= done_nx;
      if (state == IDLE && gnt_vld) begin
        grant      <= gnt_sel;
        last_grant <= gnt_sel;
        we_q       <= gnt_we;
        addr_q     <= gnt_sel ? addr[2*ADDR_W-1:ADDR_W]
                              : addr[ADDR_W-1:0];
        wdata_q    <= gnt_sel ? wdata[63:32] : wdata[31:0];
      end
      // rdata only moves on reads, so it survives writes.
      if (cmpl) begin
        resp <= we_q ? m_bresp : m_rresp;
        if (!we_q) begin
          rdata <= m_rdata;
        end
      end
    end
  end

  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = 4'hF;

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Randomized bench for axil_master_arbiter with a transaction-level model
// and a reactive AXI-Lite slave with configurable handshake delays.
module tb_axil_master_arbiter;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req = '0;
  logic [1:0]    we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [63:0]   wdata = '0;
  logic [1:0]    done;
  logic [31:0]   rdata;
  logic [1:0]    resp;
  logic [AW-1:0] m_awaddr;
  logic          m_awvalid;
  logic          m_awready = 1'b0;
  logic [31:0]   m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_wvalid;
  logic          m_wready = 1'b0;
  logic [1:0]    m_bresp = '0;
  logic          m_bvalid = 1'b0;
  logic          m_bready;
  logic [AW-1:0] m_araddr;
  logic          m_arvalid;
  logic          m_arready = 1'b0;
  logic [31:0]   m_rdata = '0;
  logic [1:0]    m_rresp = '0;
  logic          m_rvalid = 1'b0;
  logic          m_rready;

  axil_master_arbiter #(.ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .done(done), .rdata(rdata), .resp(resp),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid),
    .m_rready(m_rready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // transaction-level model
  bit          md_busy, md_cool, md_last = 1'b1, md_own, md_we;
  bit          md_awd, md_wdn, md_ard;
  logic [AW-1:0] md_addr;
  logic [31:0] md_wd;
  logic [31:0] md_rdata = '0;
  logic [1:0]  md_resp = '0;
  logic [31:0] md_mem [16];
  int          gnt_cyc, last_lat;

  // slave
  logic [31:0] sl_mem [16];
  bit          sl_aw, sl_w, sl_ar;
  logic [AW-1:0] sl_awaddr, sl_araddr;
  logic [31:0] sl_wdata;
  int          cnt_aw, cnt_w, cnt_ar, cnt_b, cnt_r;
  int          d_aw, d_w, d_ar, d_b, d_r;
  bit          fix_en = 1'b1;
  int          f_aw, f_w, f_ar, f_b, f_r;
  bit          f_resp_en = 1'b1;
  logic [1:0]  f_resp = 2'b00;
  bit          p_aw, p_w, p_ar, p_b, p_r;

  bit          auto_en, reraise;
  int          awv_hi, wv_hi;
  logic [1:0]  done_q [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic pick_delays();
    cnt_aw = 0; cnt_w = 0; cnt_ar = 0; cnt_b = 0; cnt_r = 0;
    if (fix_en) begin
      d_aw = f_aw; d_w = f_w; d_ar = f_ar; d_b = f_b; d_r = f_r;
    end else begin
      d_aw = $urandom_range(0, 3); d_w = $urandom_range(0, 3);
      d_ar = $urandom_range(0, 3); d_b = $urandom_range(0, 3);
      d_r = $urandom_range(0, 3);
    end
  endtask

  function automatic logic [1:0] pick_resp();
    if (f_resp_en) return f_resp;
    if ($urandom_range(0, 3) == 0) return 2'($urandom_range(0, 3));
    return 2'b00;
  endfunction

  // One clock: inputs seen at the coming edge are captured first,
  // outputs are sampled at the following falling edge.
  task automatic step();
    logic        rst_e;
    logic [1:0]  req_e, we_e, exp_done;
    logic [2*AW-1:0] addr_e;
    logic [63:0] wd_e;
    rst_e = reset; req_e = req; we_e = we; addr_e = addr; wd_e = wdata;
    @(negedge clock);
    cyc++;
    if (rst_e) begin
      chk("rst_ctl", {done, m_awvalid, m_wvalid, m_bready,
                      m_arvalid, m_rready, resp}, 0);
      chk("rst_data", {rdata, m_wdata}, 0);
      chk("rst_addr", {m_awaddr, m_araddr}, 0);
      md_busy = 0; md_cool = 0; md_last = 1;
      md_rdata = '0; md_resp = '0;
      sl_aw = 0; sl_w = 0; sl_ar = 0;
      m_bvalid = 1'b0; m_rvalid = 1'b0;
      pick_delays();
      req = 2'b00;
    end else begin
      if (md_cool) begin
        md_cool = 0;
      end else if (!md_busy && req_e != 2'b00) begin
        md_own  = (req_e == 2'b11) ? ~md_last : req_e[1];
        md_last = md_own;
        md_busy = 1;
        md_we   = we_e[md_own];
        md_addr = addr_e[md_own*AW +: AW];
        md_wd   = wd_e[md_own*32 +: 32];
        md_awd = 0; md_wdn = 0; md_ard = 0;
        gnt_cyc = cyc;
      end
      if (p_aw) begin md_awd = 1; sl_aw = 1; end
      if (p_w)  begin md_wdn = 1; sl_w = 1; end
      if (p_ar) begin md_ard = 1; sl_ar = 1; end
      exp_done = 2'b00;
      if (p_b || p_r) begin
        exp_done = md_own ? 2'b10 : 2'b01;
        md_busy = 0; md_cool = 1;
        // grant cycle through done cycle, both inclusive
        last_lat = cyc - gnt_cyc + 2;
        if (p_b) begin
          md_resp = m_bresp;
          if (m_bresp == 2'b00) begin
            md_mem[md_addr] = md_wd;
            sl_mem[sl_awaddr] = sl_wdata;
          end
          m_bvalid = 1'b0; sl_aw = 0; sl_w = 0;
        end else begin
          md_resp = m_rresp;
          md_rdata = md_mem[md_addr];
          m_rvalid = 1'b0; sl_ar = 0;
        end
        pick_delays();
      end
      chk("done", done, exp_done);
      if (exp_done != 2'b00) begin
        chk("rdata", rdata, md_rdata);
        chk("resp", resp, md_resp);
      end
      if (done != 2'b00) done_q.push_back(done);
      chk("awvalid", m_awvalid, md_busy && md_we && !md_awd);
      chk("wvalid", m_wvalid, md_busy && md_we && !md_wdn);
      chk("bready", m_bready, md_busy && md_we && md_awd && md_wdn);
      chk("arvalid", m_arvalid, md_busy && !md_we && !md_ard);
      chk("rready", m_rready, md_busy && !md_we && md_ard);
      chk("wstrb", m_wstrb, 4'hF);
      if (md_busy && md_we && !md_awd) chk("awaddr", m_awaddr, md_addr);
      if (md_busy && md_we && !md_wdn) chk("wdata", m_wdata, md_wd);
      if (md_busy && !md_we && !md_ard) chk("araddr", m_araddr, md_addr);
      if (m_awvalid) awv_hi++;
      if (m_wvalid) wv_hi++;
    end
    // requesters
    for (int i = 0; i < 2; i++) begin
      if (!rst_e && done[i]) req[i] = 1'b0;
      if (auto_en && !req[i] && (reraise || $urandom_range(0, 3) == 0)) begin
        req[i] = 1'b1;
        we[i] = 1'($urandom_range(0, 1));
        addr[i*AW +: AW] = {2'($urandom_range(0, 3)), 2'b00};
        wdata[i*32 +: 32] = $urandom;
      end
    end
    // slave
    p_aw = 0; p_w = 0; p_ar = 0; p_b = 0; p_r = 0;
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    if (m_awvalid && !sl_aw) begin
      if (cnt_aw >= d_aw) begin
        m_awready = 1'b1; p_aw = 1; sl_awaddr = m_awaddr;
      end else cnt_aw++;
    end
    if (m_wvalid && !sl_w) begin
      if (cnt_w >= d_w) begin
        m_wready = 1'b1; p_w = 1; sl_wdata = m_wdata;
      end else cnt_w++;
    end
    if (m_arvalid && !sl_ar) begin
      if (cnt_ar >= d_ar) begin
        m_arready = 1'b1; p_ar = 1; sl_araddr = m_araddr;
      end else cnt_ar++;
    end
    if (sl_aw && sl_w) begin
      if (!m_bvalid) begin
        if (cnt_b >= d_b) begin
          m_bvalid = 1'b1; m_bresp = pick_resp();
        end else cnt_b++;
      end
      if (m_bvalid && m_bready) p_b = 1;
    end
    if (sl_ar) begin
      if (!m_rvalid) begin
        if (cnt_r >= d_r) begin
          m_rvalid = 1'b1; m_rdata = sl_mem[sl_araddr];
          m_rresp = pick_resp();
        end else cnt_r++;
      end
      if (m_rvalid && m_rready) p_r = 1;
    end
  endtask

  task automatic wait_done(input string nm, output logic [1:0] d);
    d = 2'b00;
    for (int k = 0; k < 60; k++) begin
      step();
      if (done != 2'b00) begin
        d = done;
        break;
      end
    end
    checks++;
    if (d == 2'b00) begin
      errors++;
      $display("FAIL %s: got no done expected a done pulse", nm);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && req != 2'b00; k++) step();
    chk("drain", req, 2'b00);
    step();
    step();
  endtask

  initial begin
    logic [1:0] d;
    for (int i = 0; i < 16; i++) begin
      md_mem[i] = '0;
      sl_mem[i] = '0;
    end
    pick_delays();

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // single write, slave always ready
    req = 2'b01; we = 2'b01; addr = 8'h04; wdata = 64'h0000_00A5;
    wait_done("t1_wait", d);
    chk("t1_done", d, 2'b01);
    chk("t1_lat", last_lat, 4);
    chk("t1_resp", resp, 2'b00);

    // read back from the other requester
    req = 2'b10; we = 2'b00; addr = 8'h40;
    wait_done("t2_wait", d);
    chk("t2_done", d, 2'b10);
    chk("t2_rdata", rdata, 32'h0000_00A5);
    chk("t2_lat", last_lat, 4);
    chk("t2_resp", resp, 2'b00);

    // held tie straight after reset alternates from requester 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    done_q.delete();
    auto_en = 1; reraise = 1;
    for (int k = 0; k < 100 && done_q.size() < 4; k++) step();
    auto_en = 0; reraise = 0;
    chk("t3_count", done_q.size() >= 4, 1);
    for (int j = 0; j < 4 && j < done_q.size(); j++)
      chk("t3_order", done_q[j], (j % 2 == 1) ? 2'b10 : 2'b01);
    drain();

    // AW stalls for three cycles, W accepted at once
    f_aw = 3; pick_delays();
    awv_hi = 0; wv_hi = 0;
    req = 2'b01; we = 2'b01; addr = 8'h08; wdata = 64'h1234_5678;
    wait_done("t4_wait", d);
    chk("t4_done", d, 2'b01);
    chk("t4_awv", awv_hi, 4);
    chk("t4_wv", wv_hi, 1);
    f_aw = 0; pick_delays();
    step();

    // reset while waiting in RDATA
    f_r = 12; pick_delays();
    req = 2'b01; we = 2'b00; addr = 8'h04;
    for (int k = 0; k < 20 && m_rready !== 1'b1; k++) step();
    chk("t5_rready", m_rready, 1'b1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    f_r = 0; pick_delays();
    req = 2'b11; we = 2'b00; addr = 8'h48;
    wait_done("t5_wait0", d);
    chk("t5_first", d, 2'b01);
    wait_done("t5_wait1", d);
    chk("t5_second", d, 2'b10);
    step();

    // slave error response passes through
    f_resp = 2'b10;
    req = 2'b10; we = 2'b10; addr = 8'hC0; wdata = 64'hDEAD_BEEF_0000_0000;
    wait_done("t6_wait", d);
    chk("t6_done", d, 2'b10);
    chk("t6_resp", resp, 2'b10);
    f_resp = 2'b00;
    req = 2'b01; we = 2'b00; addr = 8'h0C;
    wait_done("t6_next", d);
    chk("t6_next_done", d, 2'b01);
    chk("t6_next_rdata", rdata, 32'h0);

    // random traffic, delays, responses and resets
    fix_en = 0; f_resp_en = 0; pick_delays();
    auto_en = 1;
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 249) == 0);
      step();
    end
    reset = 1'b0;
    auto_en = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_master_arbiter.md
AXIL_MASTER_ARBITER -- requirements
Module: axil_master_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, AXI4-Lite byte-address width; data width is fixed at 32.
REQ-002 SHALL have port clock  in  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port req  in  2  per-requester transaction request, held until its done.
REQ-005 SHALL have port we  in  2  per-requester 1=write, 0=read.
REQ-006 SHALL have port addr  in  2*ADDR_W  packed byte addresses, requester i at [i*ADDR_W +: ADDR_W].
REQ-007 SHALL have port wdata  in  64  packed write data, requester i at [i*32 +: 32].
REQ-008 SHALL have port done  out  2  one-cycle completion pulse, one-hot on the served requester.
REQ-009 SHALL have port rdata  out  32  last read data, valid while done is high.
REQ-010 SHALL have port resp  out  2  BRESP/RRESP of the completed transaction.
REQ-011 SHALL have ports m_awaddr out ADDR_W, m_awvalid out 1, m_awready in 1: AW channel.
REQ-012 SHALL have ports m_wdata out 32, m_wstrb out 4, m_wvalid out 1, m_wready in 1: W channel.
REQ-013 SHALL have ports m_bresp in 2, m_bvalid in 1, m_bready out 1: B channel.
REQ-014 SHALL have ports m_araddr out ADDR_W, m_arvalid out 1, m_arready in 1: AR channel.
REQ-015 SHALL have ports m_rdata in 32, m_rresp in 2, m_rvalid in 1, m_rready out 1: R channel; there are no PROT ports, and the integrator ties slave PROT to 3'b000.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, WRESP, READ, RDATA, DONE; all AXI and requester outputs are registered.
REQ-017 SHALL sample req only in IDLE.
- If exactly one bit is set, grant it.
- If both are set, grant the requester not equal to last_grant.
REQ-018 SHALL update last_grant on every grant and capture the granted addr, wdata and we into internal registers in the grant cycle.
REQ-019 SHALL transition IDLE->WRITE when the captured we=1 and IDLE->READ when we=0; the state is unchanged when req=2'b00.
REQ-020 SHALL, in WRITE, assert m_awvalid and m_wvalid together on entry.
- Each valid deasserts after its own valid&ready handshake.
- AW and W may complete in the same cycle or in either order.
- The FSM moves to WRESP once both handshakes are complete.
REQ-021 SHALL hold each valid high until its ready, never make valid depend on ready, and ignore ready while valid is low.
REQ-022 SHALL assert m_bready only in WRESP; on m_bvalid it latches m_bresp into resp and moves to DONE.
REQ-023 SHALL, in READ, assert m_arvalid until m_arready, then move to RDATA.
REQ-024 SHALL assert m_rready only in RDATA; on m_rvalid it latches m_rdata into rdata and m_rresp into resp, then moves to DONE.
REQ-025 SHALL, in DONE, pulse done[grant] for exactly one cycle, then return to IDLE; the requester clears req at the clock edge that ends DONE.
REQ-026 SHALL drive m_awaddr and m_araddr from the captured address, stable through the transaction, and drive m_wstrb constantly at 4'hF.
REQ-027 SHALL hold rdata unchanged across write completions; resp always reflects the latest completion.
REQ-028 SHALL complete a write in 4 cycles minimum from the IDLE grant cycle to done when the slave is always ready and responds next cycle; the read minimum is also 4 cycles.
REQ-029 SHALL pass non-OKAY responses (SLVERR=2'b10, DECERR=2'b11) through unchanged on resp, with no retry.

Reset
REQ-030 SHALL, on the cycle after reset is sampled high, set the state to IDLE from any state, including mid-transaction.
- All valid/ready outputs and done are 0.
- rdata, resp, m_awaddr, m_araddr and m_wdata are 0.
- last_grant is 1, so requester 0 wins the first tie.
REQ-031 SHALL NOT complete any abandoned transaction; the slave shares the same reset.

Verification
REQ-032 SHALL cover: req=2'b01, we=1, addr 0x4, data 0x000000A5, slave always ready -> one AW/W beat, done=2'b01 four cycles after grant, resp=0.
REQ-033 SHALL cover: req=2'b10, we=0, addr 0x4 after REQ-032 -> one AR beat, done=2'b10, rdata=0x000000A5, resp=0.
REQ-034 SHALL cover: req=2'b11 immediately after reset, held -> grants in order 0,1,0,1, each done one-hot, no back-to-back grant to the same requester.
REQ-035 SHALL cover: awready low for 3 cycles, wready immediate -> m_wvalid high 1 cycle, m_awvalid high 4 cycles with m_awaddr stable, m_bready only after both handshakes.
REQ-036 SHALL cover: reset pulsed while in RDATA -> next cycle all valids, m_rready and done are 0; a following req=2'b11 grants requester 0.
REQ-037 SHALL cover: m_bresp=2'b10 on a write -> resp=2'b10 with the done pulse, and the FSM returns to IDLE.
